// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
//   Transmit controller for the serial-out path. Two parallel-word requesters share
//   one serial line through a round-robin arbiter on a valid/ready handshake. Each
//   accepted word goes out as one frame: a start bit (0), DATA_W data bits sent
//   LSB-first, then STOP_BITS stop bits (1). Every bit is held for CLKS_PER_BIT clocks.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   req0_valid  in   requester 0 has a word
//   req0_data   in   requester 0 word, sampled on the accept edge only
//   req0_ready  out  requester 0 word accepted this cycle if valid
//   req1_valid  in   requester 1 has a word
//   req1_data   in   requester 1 word, sampled on the accept edge only
//   req1_ready  out  requester 1 word accepted this cycle if valid
//   serialOut   out  serial line, idles high, registered
//   busy        out  frame in progress, registered
//   grant_id    out  source of the current/last frame, registered

module serial_tx_scheduler #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              serialOut,
    output logic              busy,
    output logic              grant_id
);

    // Divider and bit counters keep at least one bit so CLKS_PER_BIT=1 / DATA_W=1 work.
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              rr_q, rr_d;
    logic              grant_q, grant_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;

    logic winner;
    logic idle_ok;
    logic accept;
    logic tick;

    // ------------------------------------------------------------------
    // Arbiter: a lone requester wins outright; on a tie the rr pointer decides.
    // ------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = rr_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Gating with rst keeps both ready low while reset is held, even with valid high.
    assign idle_ok    = rst && (state_q == StIdle);
    assign req0_ready = idle_ok && req0_valid && !winner;
    assign req1_ready = idle_ok && req1_valid && winner;
    assign accept     = req0_ready || req1_ready;

    // Last clock of the current bit period.
    assign tick = (clk_cnt_q == CntLast);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick && (bit_cnt_q == DataLast)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick && (bit_cnt_q == StopLast)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: divider, bit counter, shift register, arbiter state
    // ------------------------------------------------------------------
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rr_d      = rr_q;
        grant_d   = grant_q;

        if (state_q == StIdle || tick) begin
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end

        // Bit counter restarts on every state change, so DATA and STOP share it.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if ((state_q == StData || state_q == StStop) && tick) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (accept) begin
            shift_d = winner ? req1_data : req0_data;
            rr_d    = ~winner;
            grant_d = winner;
        end else if (state_q == StData && tick) begin
            shift_d = shift_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rr_q      <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Outputs are registered, so they are derived from the
    // state and shift register being entered on this edge.
    // ------------------------------------------------------------------
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            serial_q <= serial_d;
            busy_q   <= busy_d;
        end
    end

    assign serialOut = serial_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed testbench for serial_tx_scheduler: default instance (8 data bits, 4 clocks
// per bit, 1 stop bit) and a small instance (5 data bits, 1 clock per bit, 2 stop bits).

module tb_serial_tx_scheduler;

    logic clk;
    logic rst;

    logic       v0, v1, r0, r1;
    logic [7:0] d0, d1;
    logic       so, busy, gid;

    logic       p_v0, p_v1, p_r0, p_r1;
    logic [4:0] p_d0, p_d1;
    logic       p_so, p_busy, p_gid;

    int n_pass  = 0;
    int n_total = 0;

    serial_tx_scheduler #(
        .DATA_W      (8),
        .CLKS_PER_BIT(4),
        .STOP_BITS   (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(v0),
        .req0_data (d0),
        .req0_ready(r0),
        .req1_valid(v1),
        .req1_data (d1),
        .req1_ready(r1),
        .serialOut (so),
        .busy      (busy),
        .grant_id  (gid)
    );

    serial_tx_scheduler #(
        .DATA_W      (5),
        .CLKS_PER_BIT(1),
        .STOP_BITS   (2)
    ) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(p_v0),
        .req0_data (p_d0),
        .req0_ready(p_r0),
        .req1_valid(p_v1),
        .req1_data (p_d1),
        .req1_ready(p_r1),
        .serialOut (p_so),
        .busy      (p_busy),
        .grant_id  (p_gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Call right after the accept edge: samples the 40 frame clocks on negedges.
    task automatic check_frame(input string tag, input logic [7:0] data, input logic exp_gid);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk({tag, "_bit"}, so, frame[k/4]);
            if (k == 0) begin
                chk({tag, "_gid"}, gid, exp_gid);
                chk({tag, "_busy_first"}, busy, 1'b1);
                chk({tag, "_r0_after_accept"}, r0, 1'b0);
                chk({tag, "_r1_after_accept"}, r1, 1'b0);
            end
            if (k == 39) begin
                chk({tag, "_busy_last"}, busy, 1'b1);
            end
        end
    endtask

    initial begin
        logic [7:0] small_frame;

        rst  = 1'b1;
        v0   = 1'b0;
        v1   = 1'b0;
        d0   = 8'h00;
        d1   = 8'h00;
        p_v0 = 1'b0;
        p_v1 = 1'b0;
        p_d0 = 5'd0;
        p_d1 = 5'd0;

        // Reset state, with req0 valid held to show ready stays low under reset.
        #2 rst = 1'b0;
        v0 = 1'b1;
        #1;
        chk("reset_serial", so, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_gid", gid, 1'b0);
        chk("reset_r0", r0, 1'b0);
        chk("reset_r1", r1, 1'b0);
        v0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single frame 8'hA5 from req0.
        v0 = 1'b1;
        d0 = 8'hA5;
        #1;
        chk("single_r0", r0, 1'b1);
        chk("single_r1", r1, 1'b0);
        @(posedge clk);
        #1 v0 = 1'b0;
        check_frame("single", 8'hA5, 1'b0);
        @(negedge clk);
        chk("single_end_busy", busy, 1'b0);
        chk("single_end_serial", so, 1'b1);

        // Data frozen at the accept edge.
        v0 = 1'b1;
        d0 = 8'h3C;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        d0 = 8'hFF;
        check_frame("frozen", 8'h3C, 1'b0);
        @(negedge clk);

        // Back-to-back: req1 held valid for two frames.
        v1 = 1'b1;
        d1 = 8'h81;
        #1;
        chk("b2b_r1", r1, 1'b1);
        @(posedge clk);
        check_frame("b2b_a", 8'h81, 1'b1);
        @(negedge clk);
        chk("b2b_gap_busy", busy, 1'b0);
        chk("b2b_gap_serial", so, 1'b1);
        chk("b2b_gap_r1", r1, 1'b1);
        @(posedge clk);
        check_frame("b2b_b", 8'h81, 1'b1);
        @(negedge clk);
        v1 = 1'b0;

        // Mid-frame asynchronous reset during DATA (all-zero word keeps the line low).
        v0 = 1'b1;
        d0 = 8'h00;
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
        end
        chk("mid_data_serial", so, 1'b0);
        chk("mid_data_busy", busy, 1'b1);
        v0  = 1'b1;
        d0  = 8'h0F;
        v1  = 1'b1;
        d1  = 8'hF0;
        rst = 1'b0;
        #1;
        chk("async_rst_serial", so, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_r0", r0, 1'b0);
        chk("async_rst_r1", r1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Tie from reset: req0, req1, req0.
        chk("tie1_r0", r0, 1'b1);
        chk("tie1_r1", r1, 1'b0);
        @(posedge clk);
        check_frame("tie1", 8'h0F, 1'b0);
        @(negedge clk);
        chk("tie2_r0", r0, 1'b0);
        chk("tie2_r1", r1, 1'b1);
        @(posedge clk);
        check_frame("tie2", 8'hF0, 1'b1);
        @(negedge clk);
        chk("tie3_r0", r0, 1'b1);
        chk("tie3_r1", r1, 1'b0);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        check_frame("tie3", 8'h0F, 1'b0);
        @(negedge clk);
        chk("tie_end_busy", busy, 1'b0);

        // Small instance: 5'b10011, 1 clock per bit, 2 stop bits.
        p_v0 = 1'b1;
        p_d0 = 5'b10011;
        #1;
        chk("small_r0", p_r0, 1'b1);
        @(posedge clk);
        #1 p_v0 = 1'b0;
        small_frame = {2'b11, 5'b10011, 1'b0};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("small_bit", p_so, small_frame[k]);
            chk("small_busy", p_busy, 1'b1);
        end
        @(negedge clk);
        chk("small_end_busy", p_busy, 1'b0);
        chk("small_end_serial", p_so, 1'b1);
        chk("small_gid", p_gid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
